// File: rtl/sd_cmd_pkg.sv
// Shared constants and state encodings for the SD/SDIO command decoder.
package sd_cmd_pkg;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD3  = 6'd3;
  localparam logic [5:0] CMD5  = 6'd5;
  localparam logic [5:0] CMD7  = 6'd7;
  localparam logic [5:0] CMD52 = 6'd52;
  localparam logic [5:0] CMD53 = 6'd53;

  localparam logic [23:0] R4_OCR  = 24'hFF8000;
  localparam logic [37:0] R4_RESP = {6'h3F, 1'b1, 3'd1, 1'b0, 3'b000, R4_OCR};

  typedef enum logic [1:0] {
    ST_IDLE, ST_DECODE, ST_WAIT_RW, ST_SEND_RESP
  } dec_state_e;

  // Encodings match the CURRENT_STATE field of the card status word.
  typedef enum logic [3:0] {
    CS_IDLE = 4'd0, CS_STBY = 4'd3, CS_CMD = 4'd4
  } card_state_e;

  function automatic logic [31:0] card_status(input card_state_e cs);
    return {19'd0, cs, 9'd0};
  endfunction

endpackage

// File: rtl/sd_cmd_decoder.sv
// SDIO command decoder: CMD0/3/5/7/52 handling, response handshake, CRC error count.
// Define SD_CMD53_EN to add the CMD53 (extended I/O) request port set.
module sd_cmd_decoder
  import sd_cmd_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [37:0] cmd_data,
  input  logic        cmd_strobe,
  input  logic        cmd_error,
  output logic        read_enabled,
  output logic [37:0] resp_data,
  output logic        resp_no_crc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        rw_valid,
  output logic        rw_write,
  output logic [2:0]  rw_func,
  output logic        rw_raw,
  output logic [16:0] rw_addr,
  output logic [7:0]  rw_wdata,
  input  logic        rw_ready,
  input  logic [7:0]  rw_rdata,
  output logic        illegal_cmd,
`ifdef SD_CMD53_EN
  output logic        ext_valid,
  output logic        ext_write,
  output logic [2:0]  ext_func,
  output logic        ext_block,
  output logic        ext_incr,
  output logic [16:0] ext_addr,
  output logic [8:0]  ext_count,
`endif
  output logic [7:0]  crc_err_count
);

  dec_state_e  state_q, state_d;
  card_state_e cs_q, cs_d;
  logic [15:0] rca_q, rca_d, rca_inc;
  logic [37:0] cmd_q, cmd_d;
  logic [37:0] resp_data_q, resp_data_d;
  logic        resp_no_crc_q, resp_no_crc_d, resp_valid_q, resp_valid_d;
  logic        rw_valid_q, rw_valid_d, rw_write_q, rw_write_d, rw_raw_q, rw_raw_d;
  logic [2:0]  rw_func_q, rw_func_d;
  logic [16:0] rw_addr_q, rw_addr_d;
  logic [7:0]  rw_wdata_q, rw_wdata_d;
  logic        illegal_q, illegal_d;
  logic [7:0]  crc_q, crc_d;
  logic [5:0]  idx;
  logic [31:0] arg;
  logic        unused_arg_bits;

  assign idx = cmd_q[37:32];
  assign arg = cmd_q[31:0];
  assign unused_arg_bits = ^{arg[26], arg[8]};
  // RCA 0 means "unassigned", so the increment wraps to 1.
  assign rca_inc = (rca_q == 16'hFFFF) ? 16'd1 : rca_q + 16'd1;

`ifdef SD_CMD53_EN
  logic        ext_valid_q, ext_valid_d;
  logic [31:0] ext_arg_q, ext_arg_d;
`endif

  always_comb begin
    state_d       = state_q;
    cs_d          = cs_q;
    rca_d         = rca_q;
    cmd_d         = cmd_q;
    resp_data_d   = resp_data_q;
    resp_no_crc_d = resp_no_crc_q;
    resp_valid_d  = resp_valid_q;
    rw_valid_d    = rw_valid_q;
    rw_write_d    = rw_write_q;
    rw_func_d     = rw_func_q;
    rw_raw_d      = rw_raw_q;
    rw_addr_d     = rw_addr_q;
    rw_wdata_d    = rw_wdata_q;
    illegal_d     = 1'b0;
    crc_d         = (cmd_error && crc_q != 8'hFF) ? crc_q + 8'd1 : crc_q;
`ifdef SD_CMD53_EN
    ext_valid_d   = 1'b0;
    ext_arg_d     = ext_arg_q;
`endif
    case (state_q)
      ST_IDLE: if (cmd_strobe) begin
        cmd_d   = cmd_data;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d       = ST_IDLE;
        resp_no_crc_d = 1'b0;
        case (idx)
          CMD0: begin
            cs_d  = CS_IDLE;
            rca_d = 16'd0;
          end
          CMD5: begin
            cs_d          = CS_STBY;
            resp_data_d   = R4_RESP;
            resp_no_crc_d = 1'b1;
            resp_valid_d  = 1'b1;
            state_d       = ST_SEND_RESP;
          end
          CMD3: if (cs_q != CS_CMD) begin
            rca_d        = rca_inc;
            resp_data_d  = {CMD3, rca_inc, 16'h0000};
            resp_valid_d = 1'b1;
            state_d      = ST_SEND_RESP;
          end else illegal_d = 1'b1;
          CMD7: if (arg[31:16] == rca_q && rca_q != 16'd0) begin
            cs_d         = CS_CMD;
            resp_data_d  = {CMD7, card_status(CS_CMD)};
            resp_valid_d = 1'b1;
            state_d      = ST_SEND_RESP;
          end else cs_d = CS_STBY;
          CMD52: if (cs_q == CS_CMD) begin
            rw_write_d = arg[31];
            rw_func_d  = arg[30:28];
            rw_raw_d   = arg[27];
            rw_addr_d  = arg[25:9];
            rw_wdata_d = arg[7:0];
            rw_valid_d = 1'b1;
            state_d    = ST_WAIT_RW;
          end else illegal_d = 1'b1;
`ifdef SD_CMD53_EN
          CMD53: if (cs_q == CS_CMD) begin
            ext_arg_d    = arg;
            ext_valid_d  = 1'b1;
            resp_data_d  = {CMD53, 16'h0000, 8'h20, 8'h00};
            resp_valid_d = 1'b1;
            state_d      = ST_SEND_RESP;
          end else illegal_d = 1'b1;
`endif
          default: illegal_d = 1'b1;
        endcase
      end
      ST_WAIT_RW: if (rw_ready) begin
        rw_valid_d    = 1'b0;
        resp_data_d   = {CMD52, 16'h0000, 8'h20, rw_rdata};
        resp_no_crc_d = 1'b0;
        resp_valid_d  = 1'b1;
        state_d       = ST_SEND_RESP;
      end
      ST_SEND_RESP: if (resp_ready) begin
        resp_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cs_q          <= CS_IDLE;
      rca_q         <= 16'd0;
      cmd_q         <= '0;
      resp_data_q   <= '0;
      resp_no_crc_q <= 1'b0;
      resp_valid_q  <= 1'b0;
      rw_valid_q    <= 1'b0;
      rw_write_q    <= 1'b0;
      rw_func_q     <= '0;
      rw_raw_q      <= 1'b0;
      rw_addr_q     <= '0;
      rw_wdata_q    <= '0;
      illegal_q     <= 1'b0;
      crc_q         <= '0;
    end else begin
      state_q       <= state_d;
      cs_q          <= cs_d;
      rca_q         <= rca_d;
      cmd_q         <= cmd_d;
      resp_data_q   <= resp_data_d;
      resp_no_crc_q <= resp_no_crc_d;
      resp_valid_q  <= resp_valid_d;
      rw_valid_q    <= rw_valid_d;
      rw_write_q    <= rw_write_d;
      rw_func_q     <= rw_func_d;
      rw_raw_q      <= rw_raw_d;
      rw_addr_q     <= rw_addr_d;
      rw_wdata_q    <= rw_wdata_d;
      illegal_q     <= illegal_d;
      crc_q         <= crc_d;
    end
  end

  // Outputs are forced to their idle values while reset is held, even before the first edge.
  assign read_enabled  = reset | (state_q == ST_IDLE);
  assign resp_data     = reset ? '0 : resp_data_q;
  assign resp_no_crc   = ~reset & resp_no_crc_q;
  assign resp_valid    = ~reset & resp_valid_q;
  assign rw_valid      = ~reset & rw_valid_q;
  assign rw_write      = ~reset & rw_write_q;
  assign rw_func       = reset ? '0 : rw_func_q;
  assign rw_raw        = ~reset & rw_raw_q;
  assign rw_addr       = reset ? '0 : rw_addr_q;
  assign rw_wdata      = reset ? '0 : rw_wdata_q;
  assign illegal_cmd   = ~reset & illegal_q;
  assign crc_err_count = reset ? '0 : crc_q;

`ifdef SD_CMD53_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      ext_valid_q <= 1'b0;
      ext_arg_q   <= '0;
    end else begin
      ext_valid_q <= ext_valid_d;
      ext_arg_q   <= ext_arg_d;
    end
  end

  assign ext_valid = ~reset & ext_valid_q;
  assign ext_write = ~reset & ext_arg_q[31];
  assign ext_func  = reset ? '0 : ext_arg_q[30:28];
  assign ext_block = ~reset & ext_arg_q[27];
  assign ext_incr  = ~reset & ext_arg_q[26];
  assign ext_addr  = reset ? '0 : ext_arg_q[25:9];
  assign ext_count = reset ? '0 : ext_arg_q[8:0];
`endif

endmodule

// File: tb/tb_sd_cmd_decoder.sv
// Self-checking bench for sd_cmd_decoder: vector table plus handshake/reset/CRC sequences.
module tb_sd_cmd_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] cmd_data = '0;
  logic        cmd_strobe = 1'b0, cmd_error = 1'b0;
  logic        read_enabled;
  logic [37:0] resp_data;
  logic        resp_no_crc, resp_valid;
  logic        resp_ready = 1'b1;
  logic        rw_valid, rw_write, rw_raw;
  logic [2:0]  rw_func;
  logic [16:0] rw_addr;
  logic [7:0]  rw_wdata;
  logic        rw_ready = 1'b0;
  logic [7:0]  rw_rdata = '0;
  logic        illegal_cmd;
  logic [7:0]  crc_err_count;
`ifdef SD_CMD53_EN
  logic        ext_valid, ext_write, ext_block, ext_incr;
  logic [2:0]  ext_func;
  logic [16:0] ext_addr;
  logic [8:0]  ext_count;
`endif

  sd_cmd_decoder dut (
    .clock(clock), .reset(reset),
    .cmd_data(cmd_data), .cmd_strobe(cmd_strobe), .cmd_error(cmd_error),
    .read_enabled(read_enabled),
    .resp_data(resp_data), .resp_no_crc(resp_no_crc), .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .rw_valid(rw_valid), .rw_write(rw_write), .rw_func(rw_func), .rw_raw(rw_raw),
    .rw_addr(rw_addr), .rw_wdata(rw_wdata), .rw_ready(rw_ready), .rw_rdata(rw_rdata),
    .illegal_cmd(illegal_cmd),
`ifdef SD_CMD53_EN
    .ext_valid(ext_valid), .ext_write(ext_write), .ext_func(ext_func),
    .ext_block(ext_block), .ext_incr(ext_incr), .ext_addr(ext_addr),
    .ext_count(ext_count),
`endif
    .crc_err_count(crc_err_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [37:0] data;
    logic        no_crc;
  } exp_t;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    bit          has_resp;
    logic [37:0] resp;
    bit          no_crc;
    bit          illegal;
  } vec_t;

  localparam logic [37:0] R4  = 38'h3F_90FF8000;
  localparam logic [37:0] ST7 = {6'd7, 32'h0000_0800};

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0, failures = 0, resp_seen = 0;
  vec_t vecs[15];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(input logic [5:0] idx, input logic [31:0] arg, input bit has_resp,
                              input logic [37:0] resp, input bit no_crc, input bit illegal);
    vec_t v;
    v.idx = idx; v.arg = arg; v.has_resp = has_resp;
    v.resp = resp; v.no_crc = no_crc; v.illegal = illegal;
    return v;
  endfunction

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg);
    @(posedge clock); #1;
    cmd_data   = {idx, arg};
    cmd_strobe = 1'b1;
    @(posedge clock); #1;
    cmd_strobe = 1'b0;
  endtask

  // Response scoreboard: every completed handshake pops one expectation.
  always @(negedge clock) begin
    if (!reset && resp_valid && resp_ready) begin
      resp_seen++;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL resp_unexpected: got %0h expected none", resp_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_data", resp_data, mon_e.data);
        check("resp_no_crc", resp_no_crc, mon_e.no_crc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, ill_n, lat, stable;
    logic [31:0] a;

    vecs[0]  = mk(6'd0,  32'h0,         0, '0, 0, 0);
    vecs[1]  = mk(6'd52, 32'h8000_0A55, 0, '0, 0, 1);
    vecs[2]  = mk(6'd5,  32'h0,         1, R4, 1, 0);
    vecs[3]  = mk(6'd7,  32'h0000_0000, 0, '0, 0, 0);
    vecs[4]  = mk(6'd3,  32'h0,         1, {6'd3, 16'h0001, 16'h0000}, 0, 0);
    vecs[5]  = mk(6'd7,  32'h0002_0000, 0, '0, 0, 0);
    vecs[6]  = mk(6'd52, 32'h0000_0200, 0, '0, 0, 1);
    vecs[7]  = mk(6'd7,  32'h0001_0000, 1, ST7, 0, 0);
    vecs[8]  = mk(6'd3,  32'h0,         0, '0, 0, 1);
`ifdef SD_CMD53_EN
    vecs[9]  = mk(6'd53, 32'h0,         1, {6'd53, 16'h0, 8'h20, 8'h00}, 0, 0);
`else
    vecs[9]  = mk(6'd53, 32'h0,         0, '0, 0, 1);
`endif
    vecs[10] = mk(6'd6,  32'h0,         0, '0, 0, 1);
    vecs[11] = mk(6'd7,  32'h0003_0000, 0, '0, 0, 0);
    vecs[12] = mk(6'd3,  32'h0,         1, {6'd3, 16'h0002, 16'h0000}, 0, 0);
    vecs[13] = mk(6'd7,  32'h0002_0000, 1, ST7, 0, 0);
    vecs[14] = mk(6'd63, 32'hFFFF_FFFF, 0, '0, 0, 1);

    // Outputs are idle while reset is held, before and after clock edges.
    #2;
    check("rst0_read_enabled", read_enabled, 1);
    check("rst0_resp_data", resp_data, 0);
    check("rst0_crc", crc_err_count, 0);
    repeat (3) @(posedge clock);
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rw_valid", rw_valid, 0);
    check("rst_illegal", illegal_cmd, 0);
    check("rst_read_enabled", read_enabled, 1);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].has_resp) exp_q.push_back('{vecs[i].resp, vecs[i].no_crc});
      base = resp_seen;
      send_cmd(vecs[i].idx, vecs[i].arg);
      ill_n = 0; lat = 0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clock);
        if (illegal_cmd) ill_n++;
        if (resp_valid && lat == 0) lat = k;
      end
      check($sformatf("vec%0d_illegal", i), ill_n, vecs[i].illegal ? 1 : 0);
      check($sformatf("vec%0d_resp_cnt", i), resp_seen - base, vecs[i].has_resp ? 1 : 0);
      if (vecs[i].has_resp) check($sformatf("vec%0d_latency", i), lat, 2);
    end

    // CMD52 write with rw_ready held off for 3 cycles.
    rw_ready = 1'b0;
    exp_q.push_back('{{6'd52, 16'h0000, 8'h20, 8'hA5}, 1'b0});
    base = resp_seen;
    send_cmd(6'd52, 32'h8000_0A55);
    repeat (2) @(negedge clock);
    check("w52_rw_valid", rw_valid, 1);
    check("w52_rw_write", rw_write, 1);
    check("w52_rw_addr", rw_addr, 17'd5);
    check("w52_rw_wdata", rw_wdata, 8'h55);
    check("w52_read_enabled", read_enabled, 0);
    stable = 0;
    repeat (3) begin
      @(negedge clock);
      if (rw_valid && !resp_valid) stable++;
    end
    check("w52_wait_hold", stable, 3);
    @(posedge clock); #1;
    rw_ready = 1'b1; rw_rdata = 8'hA5;
    @(posedge clock); #1;
    rw_ready = 1'b0; rw_rdata = 8'h00;
    repeat (3) @(negedge clock);
    check("w52_rw_valid_drop", rw_valid, 0);
    check("w52_resp_cnt", resp_seen - base, 1);

    // CMD52 read with rw_ready already high: field decode of func/raw/addr.
    a = {1'b0, 3'd5, 1'b1, 1'b0, 17'h1ABCD, 1'b0, 8'h3C};
    rw_ready = 1'b1; rw_rdata = 8'h5A;
    exp_q.push_back('{{6'd52, 16'h0000, 8'h20, 8'h5A}, 1'b0});
    base = resp_seen;
    send_cmd(6'd52, a);
    repeat (2) @(negedge clock);
    check("r52_rw_valid", rw_valid, 1);
    check("r52_fields", {rw_write, rw_func, rw_raw, rw_addr, rw_wdata},
          {1'b0, 3'd5, 1'b1, 17'h1ABCD, 8'h3C});
    repeat (3) @(negedge clock);
    check("r52_resp_cnt", resp_seen - base, 1);
    rw_ready = 1'b0;

    // CMD5 with resp_ready low: response held; a stray CMD0 strobe is ignored.
    resp_ready = 1'b0;
    exp_q.push_back('{R4, 1'b1});
    base = resp_seen;
    send_cmd(6'd5, 32'h0);
    repeat (2) @(negedge clock);
    check("hold_first", {resp_valid, resp_no_crc, resp_data}, {1'b1, 1'b1, R4});
    @(posedge clock); #1;
    cmd_data = {6'd0, 32'h0}; cmd_strobe = 1'b1;
    stable = 0;
    repeat (5) begin
      @(negedge clock);
      if (resp_valid && resp_no_crc && resp_data == R4 && !read_enabled) stable++;
    end
    check("hold_stable", stable, 5);
    @(posedge clock); #1;
    cmd_strobe = 1'b0; resp_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("hold_release_valid", resp_valid, 0);
    check("hold_release_idle", read_enabled, 1);
    check("hold_resp_cnt", resp_seen - base, 1);

    // CRC error pulses: count saturates and never disturbs the decoder.
    @(posedge clock); #1; cmd_error = 1'b1;
    @(posedge clock); #1; cmd_error = 1'b0;
    @(negedge clock);
    check("crc_first", crc_err_count, 1);
    repeat (299) begin
      @(posedge clock); #1; cmd_error = 1'b1;
      @(posedge clock); #1; cmd_error = 1'b0;
    end
    @(negedge clock);
    check("crc_saturate", crc_err_count, 8'hFF);
    check("crc_idle", read_enabled, 1);

    // Reselect (RCA still 2 since CMD0 was ignored), then reset during ST_WAIT_RW.
    exp_q.push_back('{ST7, 1'b0});
    base = resp_seen;
    send_cmd(6'd7, 32'h0002_0000);
    repeat (4) @(negedge clock);
    check("resel_resp_cnt", resp_seen - base, 1);
    send_cmd(6'd52, 32'h0000_0200);
    repeat (2) @(negedge clock);
    check("rstrw_pre_valid", rw_valid, 1);
    @(posedge clock); #1; reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    check("rstrw_rw_valid", rw_valid, 0);
    check("rstrw_read_enabled", read_enabled, 1);
    check("rstrw_crc", crc_err_count, 0);
    check("rstrw_resp_valid", resp_valid, 0);

    // RCA restarts at 1 after reset; CMD52 is illegal again.
    exp_q.push_back('{R4, 1'b1});
    exp_q.push_back('{{6'd3, 16'h0001, 16'h0000}, 1'b0});
    base = resp_seen;
    send_cmd(6'd5, 32'h0);
    repeat (4) @(negedge clock);
    send_cmd(6'd3, 32'h0);
    repeat (4) @(negedge clock);
    check("post_rst_resp_cnt", resp_seen - base, 2);
    send_cmd(6'd52, 32'h0);
    ill_n = 0;
    repeat (4) begin
      @(negedge clock);
      if (illegal_cmd) ill_n++;
    end
    check("post_rst_illegal", ill_n, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
